// File: rtl/bcp_ctrl.sv
// bcp_ctrl - Boolean-constraint-propagation sequencer for the lit1 clause array.
//
// Takes one decision (var, value), writes it into the clause array, waits for
// the free-literal-count chains to settle and evaluates every clause. Unit
// clauses are fetched one at a time; each implication is reported to the trail
// and written back, followed by a fresh evaluation. Stops on "nothing to
// imply", on a conflict, or when MAX_IMP implications have been made.
//
// States:
//   state  | meaning
//   IDLE   | waiting for a start with a legal decision value
//   WRITE  | one-cycle array write of the latched (var, value) pair
//   SETTLE | wait SETTLE_CYC cycles for the free-literal counts to propagate
//   EVAL   | classify clauses: conflict > unit > nothing left to imply
//   FETCH  | select the latched unit clause, read and report its implication
//   DONE   | one-cycle completion pulse, results held afterwards
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start_i               request BCP for dec_var_i / dec_value_i (1=false, 2=true)
//   busy_o, done_o        busy from the cycle after accept until done; done pulse
//   conflict_o            conflict found (held until next accepted start)
//   conflict_cls_o        index of the conflicting clause (held)
//   overflow_o            MAX_IMP implications reached (held)
//   arr_wr_o/var/value    array write strobe and the pair being written
//   cls_freecnt_i         2 bits per clause: 0 none, 1 one, 2/3 two or more
//   cls_sat_i             per-clause satisfied flag
//   imp_sel_o             one-hot implication select into the array
//   imp_var_i/value_i     free literal of the selected clause (same cycle)
//   imp_valid_o/var/value implication pulse for the trail
module bcp_ctrl #(
  parameter int NUM_C      = 8,
  parameter int CLS_W      = 3,
  parameter int VAR_W      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_IMP    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [VAR_W-1:0]   dec_var_i,
  input  logic [1:0]         dec_value_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               conflict_o,
  output logic [CLS_W-1:0]   conflict_cls_o,
  output logic               overflow_o,
  output logic               arr_wr_o,
  output logic [VAR_W-1:0]   arr_var_o,
  output logic [1:0]         arr_value_o,
  input  logic [2*NUM_C-1:0] cls_freecnt_i,
  input  logic [NUM_C-1:0]   cls_sat_i,
  output logic [NUM_C-1:0]   imp_sel_o,
  input  logic [VAR_W-1:0]   imp_var_i,
  input  logic [1:0]         imp_value_i,
  output logic               imp_valid_o,
  output logic [VAR_W-1:0]   imp_var_o,
  output logic [1:0]         imp_value_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_FETCH  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;

  logic [VAR_W-1:0]   wr_var_q;
  logic [1:0]         wr_value_q;
  logic [2:0]         settle_q;
  logic [3:0]         imp_cnt_q;
  logic [CLS_W-1:0]   unit_cls_q;
  logic               conflict_q;
  logic [CLS_W-1:0]   conflict_cls_q;
  logic               overflow_q;

  logic               start_ok;
  logic               imp_value_ok;
  logic               at_max;
  logic [NUM_C-1:0]   conf_vec;
  logic [NUM_C-1:0]   unit_vec;
  logic               any_conf;
  logic               any_unit;
  logic [CLS_W-1:0]   conf_idx;
  logic [CLS_W-1:0]   unit_idx;

  assign start_ok     = start_i && ((dec_value_i == 2'd1) || (dec_value_i == 2'd2));
  assign imp_value_ok = (imp_value_i == 2'd1) || (imp_value_i == 2'd2);
  // Compared against the post-increment count: the implication made in this
  // FETCH is the one that may hit the limit.
  assign at_max       = (imp_cnt_q + 4'd1) == 4'(MAX_IMP);

  // Per-clause classification. A freecnt of 2 is illegal and falls into the
  // "two or more" bucket simply by matching neither 0 nor 1.
  always_comb begin
    conf_vec = '0;
    unit_vec = '0;
    for (int i = 0; i < NUM_C; i++) begin
      conf_vec[i] = !cls_sat_i[i] && (cls_freecnt_i[2*i +: 2] == 2'd0);
      unit_vec[i] = !cls_sat_i[i] && (cls_freecnt_i[2*i +: 2] == 2'd1);
    end
  end

  // Lowest-index priority: scan downwards so the last hit wins.
  always_comb begin
    any_conf = 1'b0;
    any_unit = 1'b0;
    conf_idx = '0;
    unit_idx = '0;
    for (int i = NUM_C - 1; i >= 0; i--) begin
      if (conf_vec[i]) begin
        any_conf = 1'b1;
        conf_idx = CLS_W'(i);
      end
      if (unit_vec[i]) begin
        any_unit = 1'b1;
        unit_idx = CLS_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 3'd0) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (any_conf)      state_d = ST_DONE;
        else if (any_unit) state_d = ST_FETCH;
        else               state_d = ST_DONE;
      end
      ST_FETCH: begin
        if (!imp_value_ok) state_d = ST_DONE;
        else if (at_max)   state_d = ST_DONE;
        else               state_d = ST_WRITE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: write pair, settle timer, implication counter, results
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_var_q       <= '0;
      wr_value_q     <= '0;
      settle_q       <= '0;
      imp_cnt_q      <= '0;
      unit_cls_q     <= '0;
      conflict_q     <= 1'b0;
      conflict_cls_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            wr_var_q       <= dec_var_i;
            wr_value_q     <= dec_value_i;
            imp_cnt_q      <= '0;
            conflict_q     <= 1'b0;
            conflict_cls_q <= '0;
            overflow_q     <= 1'b0;
          end
        end
        ST_WRITE: begin
          // Down-counter: SETTLE leaves when it reads zero, so load N-1
          // to spend exactly SETTLE_CYC cycles there.
          settle_q <= 3'(SETTLE_CYC - 1);
        end
        ST_SETTLE: begin
          if (settle_q != 3'd0) settle_q <= settle_q - 3'd1;
        end
        ST_EVAL: begin
          if (any_conf) begin
            conflict_q     <= 1'b1;
            conflict_cls_q <= conf_idx;
          end else if (any_unit) begin
            unit_cls_q <= unit_idx;
          end
        end
        ST_FETCH: begin
          if (!imp_value_ok) begin
            // A unit clause whose free literal has no legal value is
            // reported as a conflict on that clause.
            conflict_q     <= 1'b1;
            conflict_cls_q <= unit_cls_q;
          end else begin
            wr_var_q   <= imp_var_i;
            wr_value_q <= imp_value_i;
            imp_cnt_q  <= imp_cnt_q + 4'd1;
            if (at_max) overflow_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    arr_wr_o    = 1'b0;
    arr_var_o   = '0;
    arr_value_o = '0;
    imp_sel_o   = '0;
    imp_valid_o = 1'b0;
    imp_var_o   = '0;
    imp_value_o = '0;
    if (state_q == ST_WRITE) begin
      arr_wr_o    = 1'b1;
      arr_var_o   = wr_var_q;
      arr_value_o = wr_value_q;
    end
    if (state_q == ST_FETCH) begin
      imp_sel_o = {{(NUM_C-1){1'b0}}, 1'b1} << unit_cls_q;
      if (imp_value_ok) begin
        imp_valid_o = 1'b1;
        imp_var_o   = imp_var_i;
        imp_value_o = imp_value_i;
      end
    end
  end

  assign conflict_o     = conflict_q;
  assign conflict_cls_o = conflict_cls_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_bcp_ctrl.sv
module tb_bcp_ctrl;
  localparam int NUM_C   = 8;
  localparam int MAX_IMP = 15;
  localparam int MAXR    = 16;
  localparam int MAXT    = 72;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [3:0]  dec_var_i;
  logic [1:0]  dec_value_i;
  logic        busy_o, done_o, conflict_o, overflow_o;
  logic [2:0]  conflict_cls_o;
  logic        arr_wr_o;
  logic [3:0]  arr_var_o;
  logic [1:0]  arr_value_o;
  logic [15:0] cls_freecnt_i;
  logic [7:0]  cls_sat_i;
  logic [7:0]  imp_sel_o;
  logic [3:0]  imp_var_i;
  logic [1:0]  imp_value_i;
  logic        imp_valid_o;
  logic [3:0]  imp_var_o;
  logic [1:0]  imp_value_o;

  bcp_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dec_var_i(dec_var_i),
    .dec_value_i(dec_value_i), .busy_o(busy_o), .done_o(done_o),
    .conflict_o(conflict_o), .conflict_cls_o(conflict_cls_o),
    .overflow_o(overflow_o), .arr_wr_o(arr_wr_o), .arr_var_o(arr_var_o),
    .arr_value_o(arr_value_o), .cls_freecnt_i(cls_freecnt_i),
    .cls_sat_i(cls_sat_i), .imp_sel_o(imp_sel_o), .imp_var_i(imp_var_i),
    .imp_value_i(imp_value_i), .imp_valid_o(imp_valid_o),
    .imp_var_o(imp_var_o), .imp_value_o(imp_value_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Array contents seen after each write (round r = after the r-th write).
  logic [15:0] r_fc   [MAXR];
  logic [7:0]  r_sat  [MAXR];
  logic [3:0]  r_iv   [MAXR];
  logic [1:0]  r_ival [MAXR];

  // Expected per-cycle activity, indexed by cycles after the accepting edge.
  logic        e_wr   [MAXT];
  logic [3:0]  e_av   [MAXT];
  logic [1:0]  e_aval [MAXT];
  logic        e_iv   [MAXT];
  logic [3:0]  e_ivar [MAXT];
  logic [1:0]  e_ival [MAXT];
  logic [7:0]  e_sel  [MAXT];
  int          e_done;
  logic        e_conf;
  logic [2:0]  e_cls;
  logic        e_ovf;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [23:0] obs_now();
    return {busy_o, done_o, arr_wr_o, arr_var_o, arr_value_o, imp_valid_o,
            imp_valid_o ? {imp_var_o, imp_value_o} : 6'd0, imp_sel_o};
  endfunction

  function automatic logic [23:0] exp_at(input int n);
    return {(n >= 1 && n <= e_done), (n == e_done), e_wr[n], e_av[n], e_aval[n], e_iv[n],
            e_iv[n] ? {e_ivar[n], e_ival[n]} : 6'd0, e_sel[n]};
  endfunction

  function automatic logic [31:0] flags_now();
    return 32'({conflict_o, conflict_cls_o, overflow_o});
  endfunction

  task automatic set_all_sat(input int r);
    r_fc[r] = 16'hFFFF; r_sat[r] = 8'hFF; r_iv[r] = 4'd0; r_ival[r] = 2'd1;
  endtask

  task automatic drive_round(input int r);
    cls_freecnt_i = r_fc[r]; cls_sat_i = r_sat[r];
    imp_var_i = r_iv[r]; imp_value_i = r_ival[r];
  endtask

  task automatic rand_round(input int r);
    logic [15:0] fc;
    logic [7:0]  sat;
    int k;
    fc = '0; sat = '0;
    for (int i = 0; i < NUM_C; i++) begin
      k = $urandom_range(0, 31);
      if (k == 0)      begin fc[2*i +: 2] = 2'd0; sat[i] = 1'b0; end
      else if (k < 6)  begin fc[2*i +: 2] = 2'd1; sat[i] = 1'b0; end
      else if (k < 12) begin fc[2*i +: 2] = 2'($urandom_range(2, 3)); sat[i] = 1'b0; end
      else             begin fc[2*i +: 2] = 2'($urandom_range(0, 3)); sat[i] = 1'b1; end
    end
    r_fc[r] = fc; r_sat[r] = sat; r_iv[r] = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 9) == 0) r_ival[r] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
    else                           r_ival[r] = 2'($urandom_range(1, 2));
  endtask

  // Reference: walk the evaluation rounds with the classification rules.
  task automatic build_expect(input logic [3:0] dv, input logic [1:0] dval);
    int t, r, imps, c, u, f;
    logic [3:0] wv;
    logic [1:0] wval, fc;
    bit fin;
    for (int n = 0; n < MAXT; n++) begin
      e_wr[n] = 0; e_av[n] = 0; e_aval[n] = 0; e_iv[n] = 0;
      e_ivar[n] = 0; e_ival[n] = 0; e_sel[n] = 0;
    end
    t = 1; r = 0; imps = 0; wv = dv; wval = dval; fin = 0;
    e_conf = 0; e_cls = 0; e_ovf = 0; e_done = 0;
    while (!fin) begin
      e_wr[t] = 1; e_av[t] = wv; e_aval[t] = wval;
      c = -1; u = -1;
      for (int i = 0; i < NUM_C; i++) begin
        fc = r_fc[r][2*i +: 2];
        if (!r_sat[r][i]) begin
          if (c < 0 && fc == 2'd0) c = i;
          if (u < 0 && fc == 2'd1) u = i;
        end
      end
      if (c >= 0) begin
        e_conf = 1; e_cls = 3'(c); e_done = t + 3; fin = 1;
      end else if (u < 0) begin
        e_done = t + 3; fin = 1;
      end else begin
        f = t + 3;
        e_sel[f] = 8'(1 << u);
        if (r_ival[r] != 2'd1 && r_ival[r] != 2'd2) begin
          e_conf = 1; e_cls = 3'(u); e_done = f + 1; fin = 1;
        end else begin
          e_iv[f] = 1; e_ivar[f] = r_iv[r]; e_ival[f] = r_ival[r];
          imps++;
          if (imps == MAX_IMP) begin
            e_ovf = 1; e_done = f + 1; fin = 1;
          end else begin
            wv = r_iv[r]; wval = r_ival[r]; r++; t = f + 1;
          end
        end
      end
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] dv, input logic [1:0] dval,
                        input bit stray);
    int wcount;
    wcount = 0;
    build_expect(dv, dval);
    @(negedge clk);
    drive_round(0);
    start_i = 1; dec_var_i = dv; dec_value_i = dval;
    for (int n = 1; n <= e_done + 2; n++) begin
      @(negedge clk);
      if (n <= e_done) chk($sformatf("%s_cyc%0d", name, n), 32'(obs_now()), 32'(exp_at(n)));
      else             chk($sformatf("%s_idle%0d", name, n), 32'(obs_now()), 32'd0);
      if (n >= e_done)
        chk($sformatf("%s_flags%0d", name, n), flags_now(), 32'({e_conf, e_cls, e_ovf}));
      if (arr_wr_o) begin
        if (wcount < MAXR) drive_round(wcount);
        wcount++;
      end
      start_i = 0;
      if (stray && n < e_done - 1 && $urandom_range(0, 2) == 0) begin
        start_i = 1; dec_var_i = 4'($urandom_range(0, 15));
        dec_value_i = 2'($urandom_range(1, 2));
      end
    end
    start_i = 0;
  endtask

  initial begin
    int found;
    rst = 1; start_i = 1; dec_var_i = 4'd5; dec_value_i = 2'd2;
    set_all_sat(0); drive_round(0);

    // Reset held with start asserted: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", 32'(obs_now()), 32'd0);
      chk("rst_flags", flags_now(), 32'd0);
    end
    rst = 0;
    @(negedge clk);
    chk("rst_first_wr", 32'({arr_wr_o, arr_var_o, arr_value_o}), 32'({1'b1, 4'd5, 2'd2}));
    start_i = 0;
    found = 0;
    for (int n = 2; n <= 10 && found == 0; n++) begin
      @(negedge clk);
      if (done_o) found = n;
    end
    chk("rst_done_cycle", 32'(found), 32'd4);

    // All clauses satisfied after the decision.
    set_all_sat(0);
    run_op("allsat", 4'd3, 2'd2, 0);

    // Clauses 2 and 5 unit; clause 2 is chosen, then all satisfied.
    r_fc[0] = 16'hF7DF; r_sat[0] = 8'hDB; r_iv[0] = 4'd6; r_ival[0] = 2'd2;
    set_all_sat(1);
    run_op("unit2", 4'd1, 2'd1, 0);

    // Clause 4 unit and clause 6 conflicting together: conflict wins.
    r_fc[0] = 16'hCDFF; r_sat[0] = 8'hAF; r_iv[0] = 4'd2; r_ival[0] = 2'd1;
    run_op("conf6", 4'd7, 2'd2, 0);

    // Clause 0 stays unit forever: implication limit.
    for (int r = 0; r < MAXR; r++) begin
      r_fc[r] = 16'hFFFD; r_sat[r] = 8'hFE;
      r_iv[r] = 4'(r + 1); r_ival[r] = 2'((r % 2) + 1);
    end
    run_op("ovf", 4'd0, 2'd1, 1);

    // Start with illegal decision values in IDLE is ignored.
    @(negedge clk);
    start_i = 1; dec_var_i = 4'd4; dec_value_i = 2'd0;
    @(negedge clk);
    chk("bad_start_v0", 32'(obs_now()), 32'd0);
    dec_value_i = 2'd3;
    @(negedge clk);
    chk("bad_start_v3", 32'(obs_now()), 32'd0);
    start_i = 0;
    @(negedge clk);
    chk("bad_start_v3b", 32'(obs_now()), 32'd0);

    // Reset during SETTLE aborts without a done pulse.
    set_all_sat(0); drive_round(0);
    start_i = 1; dec_var_i = 4'd9; dec_value_i = 2'd1;
    @(negedge clk);
    start_i = 0;
    chk("abort_write", 32'(arr_wr_o), 32'd1);
    @(negedge clk);
    chk("abort_settle_busy", 32'({busy_o, arr_wr_o}), 32'b10);
    rst = 1;
    @(negedge clk);
    chk("abort_idle", 32'(obs_now()), 32'd0);
    rst = 0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_quiet", 32'(obs_now()), 32'd0);
    end

    // Randomized rounds with stray starts while busy.
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < MAXR; r++) rand_round(r);
      run_op($sformatf("rnd%0d", it), 4'($urandom_range(0, 15)),
             2'($urandom_range(1, 2)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcp_ctrl.md
Name: bcp_ctrl

Overview:
- Boolean-constraint-propagation sequencer for the lit1 clause array.
- Takes one decision (var, value), broadcasts it to the array as a write, waits for the free-literal-count chains to settle, then evaluates every clause.
- Repeatedly fetches and writes implications from unit clauses until there is nothing left to imply or a conflict occurs.
- Sits between the decision/trail logic and the clause array; it is the only driver of the array's write and implication-select inputs.

Parameters:
- NUM_C, 8: number of clauses in the array.
- CLS_W, 3: clause index width (ceil log2 NUM_C).
- VAR_W, 4: variable index width.
- SETTLE_CYC, 1: cycles waited after each write before evaluation (1..7).
- MAX_IMP, 15: maximum implications per start; must fit in 4 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request BCP for the decision on dec_var_i/dec_value_i
- dec_var_i  in  VAR_W  decision variable
- dec_value_i  in  2  decision value, 1=false, 2=true
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- conflict_o  out  1  result flag, held until next accepted start
- conflict_cls_o  out  CLS_W  conflicting clause index, held
- overflow_o  out  1  MAX_IMP reached, held
- arr_wr_o  out  1  array write strobe (lit wr_i)
- arr_var_o  out  VAR_W  variable being written
- arr_value_o  out  2  value being written (lit var_value_i[2:1])
- cls_freecnt_i  in  2*NUM_C  per-clause final freelitcnt; 0 = none, 1 = exactly one, 3 = two or more, 2 = illegal (treated as 3)
- cls_sat_i  in  NUM_C  per-clause clausesat
- imp_sel_o  out  NUM_C  one-hot implication select (imp_drv_i of the chosen clause)
- imp_var_i  in  VAR_W  free-literal variable of the selected clause, combinational, valid in the same cycle
- imp_value_i  in  2  value that satisfies that literal
- imp_valid_o  out  1  one-cycle pulse per implication, for the trail
- imp_var_o  out  VAR_W  implied variable, valid with imp_valid_o
- imp_value_o  out  2  implied value, valid with imp_valid_o

Behaviour:
- Reset: state IDLE. All outputs 0, the implication counter 0, the settle counter 0. Reset mid-operation aborts immediately; no further array write is issued.
- States: IDLE, WRITE, SETTLE, EVAL, FETCH, DONE.
- IDLE: start_i is accepted only when dec_value_i is 1 or 2. On accept, latch var/value, clear conflict_o, conflict_cls_o, overflow_o and the implication counter, then go to WRITE. start_i in any other state is ignored.
- WRITE: arr_wr_o=1 with arr_var_o/arr_value_o = latched pair for exactly one cycle, then SETTLE. Outside WRITE, arr_wr_o=0, arr_var_o=0, arr_value_o=0.
- SETTLE: stay for SETTLE_CYC cycles, then EVAL.
- EVAL, all classification on the current cycle's inputs:
  - A clause is conflicting when cls_sat_i=0 and freecnt=0.
  - A clause is unit when cls_sat_i=0 and freecnt=1.
  - Any conflicting clause: conflict_o=1, conflict_cls_o = lowest conflicting index, go to DONE. Conflict takes priority over unit.
  - Else any unit clause: latch the lowest unit index, go to FETCH.
  - Else go to DONE.
- FETCH: imp_sel_o = one-hot of the latched index for one cycle.
  - If imp_value_i is not 1 or 2: conflict_o=1, conflict_cls_o = that index, go to DONE.
  - Otherwise: imp_valid_o=1 with imp_var_o/imp_value_o = inputs, latch them as the next write pair, and increment the counter.
  - If the counter now equals MAX_IMP: overflow_o=1, go to DONE. Otherwise go to WRITE.
- DONE: done_o=1 for one cycle, then IDLE. Results stay stable until the next accepted start.
- busy_o=1 in WRITE, SETTLE, EVAL, FETCH and DONE.
- Latency with SETTLE_CYC=1, start sampled at edge k:
  - WRITE in cycle k+1, SETTLE k+2, EVAL k+3, done_o in cycle k+4.
  - Each implication adds 4 cycles (FETCH, WRITE, SETTLE, EVAL).
- One implication per evaluation round. The array is re-evaluated after every write; it is never batched.

Test Plan:
- Reset with start_i=1 held: all outputs stay 0 until rst releases; the first accepted start produces arr_wr_o in the cycle after acceptance.
- Start var 3, value 2; array returns all clauses sat: arr_wr_o only in cycle k+1 with var 3/value 2; done_o in cycle k+4; conflict_o=0; imp_valid_o never asserted.
- Start var 1, value 1; after the first write clauses 2 and 5 are unit (imp_var 6, value 2); after the second write everything is sat: imp_sel_o=8'b00000100 (clause 2 chosen); imp_valid_o once with (6,2); second write of (6,2); done_o in cycle k+8.
- Clause 4 unit and clause 6 conflicting in the same EVAL: conflict_o=1, conflict_cls_o=6, no FETCH, done_o at k+4.
- Array keeps reporting clause 0 unit with fresh vars: 15 imp_valid_o pulses, then overflow_o=1 and done_o.
- start_i pulsed while busy, and start_i with dec_value_i=0 or 3 while IDLE: both ignored, no arr_wr_o; rst asserted during SETTLE: IDLE next cycle, no done_o.
